// File: rtl/core_pkg.sv
// Shared RV32I core types: control bundle, result and forwarding encodings.
// Imported by every pipeline register and the hazard/forwarding logic.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 3;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: sync reset, clear-to-zero, load enable.
// Priority is reset > clr > en > hold.
module pipe_reg_en_clr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr)
      data_d = '0;
    else if (en)
      data_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register; a flush loads an all-zero bubble,
// a stall holds the current contents.
module id_ex_pipe_reg
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       pc_plus4_d,
  input  logic [XLEN-1:0]       imm_ext_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  ctrl_t                 ctrl_d,
  input  logic                  valid_d,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       pc_plus4_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output ctrl_t                 ctrl_e,
  output logic                  valid_e
);

  localparam int BUNDLE_W =
    5 * XLEN + 3 * REG_ADDR_W + $bits(ctrl_t) + 1;

  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_e;

  assign bundle_d = {rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d,
                     rs1_d, rs2_d, rd_d, ctrl_d, valid_d};

  // All-zero bubble keeps rd_e=x0 so forwarding can't match it.
  pipe_reg_en_clr #(
    .WIDTH (BUNDLE_W)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (flush_e),
    .en    (~stall_e),
    .d     (bundle_d),
    .q     (bundle_e)
  );

  assign {rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e,
          rs1_e, rs2_e, rd_e, ctrl_e, valid_e} = bundle_e;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg: reset, load, stall,
// flush, flush+stall and reset-during-stall scenarios.
module tb_id_ex_pipe_reg;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, valid_d;
  logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  ctrl_t       ctrl_d;
  logic [31:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  ctrl_t       ctrl_e;
  logic        valid_e;

  int vecs = 0;
  int errs = 0;

  localparam int AW = 5 * 32 + 3 * 5 + $bits(ctrl_t) + 1;
  logic [AW-1:0] obs_all;
  logic [AW-1:0] exp_all;
  assign obs_all = {rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e,
                    rs1_e, rs2_e, rd_e, ctrl_e, valid_e};

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk        (clk),
    .reset      (reset),
    .stall_e    (stall_e),
    .flush_e    (flush_e),
    .rd1_d      (rd1_d),
    .rd2_d      (rd2_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .imm_ext_d  (imm_ext_d),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rd_d       (rd_d),
    .ctrl_d     (ctrl_d),
    .valid_d    (valid_d),
    .rd1_e      (rd1_e),
    .rd2_e      (rd2_e),
    .pc_e       (pc_e),
    .pc_plus4_e (pc_plus4_e),
    .imm_ext_e  (imm_ext_e),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .ctrl_e     (ctrl_e),
    .valid_e    (valid_e)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [31:0] base,
                            input logic [4:0] r1, r2, rd,
                            input ctrl_t c, input logic v);
    rd1_d      = base ^ 32'h1111_1111;
    rd2_d      = base ^ 32'h2222_2222;
    pc_d       = base;
    pc_plus4_d = base + 32'd4;
    imm_ext_d  = base ^ 32'h0F0F_0F0F;
    rs1_d      = r1;
    rs2_d      = r2;
    rd_d       = rd;
    ctrl_d     = c;
    valid_d    = v;
  endtask

  task automatic test_reset();
    ctrl_t c;
    c = '1;
    set_inputs(32'hA5A5_5A5A, 5'd31, 5'd17, 5'd9, c, 1'b1);
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    tick();
    vecs++;
    if (obs_all !== '0) begin
      errs++;
      $display("FAIL reset_c1 got=%h want=0", obs_all);
    end
    tick();
    vecs++;
    if (obs_all !== '0) begin
      errs++;
      $display("FAIL reset_c2 got=%h want=0", obs_all);
    end
    vecs++;
    if (ctrl_e !== CTRL_NOP || valid_e !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctrl got=%h/%b want=0/0", ctrl_e, valid_e);
    end
  endtask

  task automatic test_load();
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write = 1'b1;
    reset = 1'b0;
    set_inputs(32'h0000_0040, 5'd5, 5'd6, 5'd7, c, 1'b1);
    rd1_d = 32'hDEAD_BEEF;
    tick();
    vecs++;
    if (rd1_e !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL load_rd1 got=%h want=deadbeef", rd1_e);
    end
    vecs++;
    if (rs1_e !== 5'd5 || rd_e !== 5'd7 || rs2_e !== 5'd6) begin
      errs++;
      $display("FAIL load_addr got=%0d/%0d/%0d want=5/6/7",
               rs1_e, rs2_e, rd_e);
    end
    vecs++;
    if (ctrl_e.reg_write !== 1'b1 || valid_e !== 1'b1) begin
      errs++;
      $display("FAIL load_ctrl got=%b/%b want=1/1",
               ctrl_e.reg_write, valid_e);
    end
    vecs++;
    if (pc_e !== 32'h40 || pc_plus4_e !== 32'h44 ||
        imm_ext_e !== 32'h0F0F_0F4F || rd2_e !== 32'h2222_2262) begin
      errs++;
      $display("FAIL load_data got=%h %h %h %h", pc_e, pc_plus4_e,
               imm_ext_e, rd2_e);
    end
    // invalid slot: control captured unmodified
    c = 10'b1_10_1_0_1_101_1;
    set_inputs(32'h0000_0080, 5'd1, 5'd2, 5'd3, c, 1'b0);
    tick();
    vecs++;
    if (ctrl_e !== 10'b1_10_1_0_1_101_1 || valid_e !== 1'b0) begin
      errs++;
      $display("FAIL load_invalid got=%b/%b want=1101011011/0",
               ctrl_e, valid_e);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pcs [3];
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C;
    set_inputs(32'h100, 5'd1, 5'd2, 5'd3, CTRL_NOP, 1'b1);
    stall_e = 1'b0;
    tick();
    exp_all = obs_all;
    vecs++;
    if (pc_e !== 32'h100) begin
      errs++;
      $display("FAIL stall_pre got=%h want=100", pc_e);
    end
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(pcs[i], 5'd9, 5'd10, 5'd11, '1, 1'b0);
      tick();
      vecs++;
      if (pc_e !== 32'h100 || rd_e !== 5'd3 || valid_e !== 1'b1 ||
          rd1_e !== 32'h1111_1011 || ctrl_e !== CTRL_NOP) begin
        errs++;
        $display("FAIL stall_hold%0d got pc=%h rd=%0d want pc=100 rd=3",
                 i, pc_e, rd_e);
      end
    end
    stall_e = 1'b0;
    tick();
    vecs++;
    if (pc_e !== 32'h10C || rd_e !== 5'd11 || valid_e !== 1'b0) begin
      errs++;
      $display("FAIL stall_release got pc=%h rd=%0d want 10c/11",
               pc_e, rd_e);
    end
  endtask

  task automatic test_flush();
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write = 1'b1;
    c.branch = 1'b1;
    set_inputs(32'h300, 5'd1, 5'd2, 5'd3, c, 1'b1);
    tick();
    vecs++;
    if (rd_e !== 5'd3 || ctrl_e !== c || valid_e !== 1'b1) begin
      errs++;
      $display("FAIL flush_pre got rd=%0d ctrl=%b", rd_e, ctrl_e);
    end
    set_inputs(32'h304, 5'd4, 5'd5, 5'd6, c, 1'b1);
    flush_e = 1'b1;
    tick();
    vecs++;
    if (obs_all !== '0) begin
      errs++;
      $display("FAIL flush_bubble got=%h want=0", obs_all);
    end
    flush_e = 1'b0;
    set_inputs(32'h308, 5'd12, 5'd13, 5'd14, c, 1'b1);
    tick();
    vecs++;
    if (pc_e !== 32'h308 || rd_e !== 5'd14 || ctrl_e !== c ||
        valid_e !== 1'b1) begin
      errs++;
      $display("FAIL flush_after got pc=%h rd=%0d want 308/14",
               pc_e, rd_e);
    end
  endtask

  task automatic test_flush_stall();
    set_inputs(32'h400, 5'd8, 5'd9, 5'd10, '1, 1'b1);
    tick();
    stall_e = 1'b1;
    flush_e = 1'b1;
    tick();
    vecs++;
    if (obs_all !== '0) begin
      errs++;
      $display("FAIL flush_stall got=%h want=0", obs_all);
    end
    flush_e = 1'b0;
    tick();
    vecs++;
    if (obs_all !== '0) begin
      errs++;
      $display("FAIL flush_stall_hold got=%h want=0", obs_all);
    end
    stall_e = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_inputs(32'h200, 5'd1, 5'd2, 5'd3, '1, 1'b1);
    tick();
    stall_e = 1'b1;
    set_inputs(32'h204, 5'd4, 5'd5, 5'd6, '1, 1'b1);
    tick();
    vecs++;
    if (pc_e !== 32'h200) begin
      errs++;
      $display("FAIL rst_stall_hold got=%h want=200", pc_e);
    end
    reset = 1'b1;
    tick();
    vecs++;
    if (obs_all !== '0) begin
      errs++;
      $display("FAIL rst_stall_clear got=%h want=0", obs_all);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (pc_e !== 32'h0 || valid_e !== 1'b0 || obs_all !== '0) begin
        errs++;
        $display("FAIL rst_stall_after%0d got pc=%h v=%b want 0/0",
                 i, pc_e, valid_e);
      end
    end
    stall_e = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    set_inputs('0, '0, '0, '0, CTRL_NOP, 1'b0);
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
